shade_arbiter: RTL and testbench

SHADE_ARBITER -- requirements
Module: shade_arbiter

---
 rtl/shade_arbiter_pkg.sv | 32 +++
 rtl/shade_channel_mul.sv | 49 ++++
 rtl/shade_arbiter.sv | 161 ++++++++++++++++
 tb/tb_shade_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shade_arbiter_pkg.sv
// Shared definitions for the shade arbiter: channel widths, source ids,
// and the 4x4 ordered-dither offset matrix.
package shade_arbiter_pkg;

    localparam int unsigned TEX_W   = 5;                // texel channel, 31 = 1.0
    localparam int unsigned GOU_W   = 9;                // gouraud channel, 256 = 1.0
    localparam int unsigned OUT_W   = 8;                // shaded output channel
    localparam int unsigned PROD_W  = TEX_W + GOU_W;    // 14-bit product
    localparam int unsigned SCALE_W = GOU_W;            // product[13:5], 0..495
    localparam int unsigned OFS_W   = 4;                // signed dither offset
    localparam int unsigned SUM_W   = SCALE_W + 2;      // signed sum with headroom

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Dither offsets, element index {y,x}; row view:
    //   y0: -4  0 -3  1
    //   y1:  2 -2  3 -1
    //   y2: -3  1 -4  0
    //   y3:  3 -1  2 -2
    localparam logic [15:0][OFS_W-1:0] DITHER_MAT = 64'hE2F3_0C1D_F3E2_1D0C;

    function automatic logic signed [OFS_W-1:0] dither_offset(
        input logic [1:0] x,
        input logic [1:0] y
    );
        return $signed(DITHER_MAT[{y, x}]);
    endfunction

endpackage

// File: rtl/shade_channel_mul.sv
// One colour channel of the shading pipeline.
// S1 registers the scaled texel*gouraud product, S2 adds the dither offset
// and clamps to 0..255.
// Ports: clk, rst (sync active-high), load (pipeline advance),
//        tex, gouraud (S1 operands), offset (S1-aligned dither offset),
//        color (registered S2 result).
module shade_channel_mul
    import shade_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [TEX_W-1:0]        tex,
    input  logic [GOU_W-1:0]        gouraud,
    input  logic signed [OFS_W-1:0] offset,
    output logic [OUT_W-1:0]        color
);

    logic [PROD_W-1:0]       prod;
    logic [SCALE_W-1:0]      scaled;
    logic signed [SUM_W-1:0] sum;
    logic [OUT_W-1:0]        clamped;
    logic                    unused_frac;

    assign prod        = PROD_W'(tex) * PROD_W'(gouraud);
    assign unused_frac = ^prod[PROD_W-SCALE_W-1:0];
    assign sum         = $signed({2'b00, scaled}) + SUM_W'(offset);

    // Negative sums clamp to 0, anything above 255 saturates.
    always_comb begin
        clamped = sum[OUT_W-1:0];
        if (sum[SUM_W-1]) begin
            clamped = '0;
        end else if (|sum[SUM_W-2:OUT_W]) begin
            clamped = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scaled <= '0;
            color  <= '0;
        end else if (load) begin
            scaled <= prod[PROD_W-1:PROD_W-SCALE_W];
            color  <= clamped;
        end
    end

endmodule

// File: rtl/shade_arbiter.sv
// Round-robin arbiter between the polygon (A) and rect/sprite (B) pixel paths
// feeding a 2-stage shading pipeline (S1 multiply, S2 dither + clamp).
// Optional feature: define SHADE_DITHER_EN to enable the 4x4 ordered dither.
// Ports: clk, i_rst (sync active-high); per requester X in {a,b}:
//        i_x_valid/o_x_ready, i_x_{r,g,b}Tex, i_x_noTexture,
//        i_x_{r,g,b}Gouraud, i_x_x, i_x_y, i_x_dither, i_x_tag;
//        result: o_valid/i_ready, o_r/o_g/o_b, o_src, o_tag; o_busy.
module shade_arbiter
    import shade_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [TEX_W-1:0] i_a_rTex,
    input  logic [TEX_W-1:0] i_a_gTex,
    input  logic [TEX_W-1:0] i_a_bTex,
    input  logic             i_a_noTexture,
    input  logic [GOU_W-1:0] i_a_rGouraud,
    input  logic [GOU_W-1:0] i_a_gGouraud,
    input  logic [GOU_W-1:0] i_a_bGouraud,
    input  logic [1:0]       i_a_x,
    input  logic [1:0]       i_a_y,
    input  logic             i_a_dither,
    input  logic [TAG_W-1:0] i_a_tag,
    input  logic             i_b_valid,
    output logic             o_b_ready,
    input  logic [TEX_W-1:0] i_b_rTex,
    input  logic [TEX_W-1:0] i_b_gTex,
    input  logic [TEX_W-1:0] i_b_bTex,
    input  logic             i_b_noTexture,
    input  logic [GOU_W-1:0] i_b_rGouraud,
    input  logic [GOU_W-1:0] i_b_gGouraud,
    input  logic [GOU_W-1:0] i_b_bGouraud,
    input  logic [1:0]       i_b_x,
    input  logic [1:0]       i_b_y,
    input  logic             i_b_dither,
    input  logic [TAG_W-1:0] i_b_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_r,
    output logic [OUT_W-1:0] o_g,
    output logic [OUT_W-1:0] o_b,
    output logic             o_src,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    logic                    advance;
    logic                    grant_a;
    logic                    grant_b;
    logic                    xfer;
    src_e                    rr_last;
    logic                    s1_valid;
    logic                    s1_src;
    logic [TAG_W-1:0]        s1_tag;
    logic signed [OFS_W-1:0] s1_offset;
    logic signed [OFS_W-1:0] offset_sel;
    logic [TEX_W-1:0]        tex_r, tex_g, tex_b;
    logic [GOU_W-1:0]        gou_r, gou_g, gou_b;
    logic [TAG_W-1:0]        tag_sel;

    // The pipe moves whenever the output slot is empty or being drained.
    assign advance = !o_valid || i_ready;

    // On conflict the requester that did not win last time gets the grant.
    assign grant_a = i_a_valid && (!i_b_valid || rr_last == SRC_B);
    assign grant_b = i_b_valid && (!i_a_valid || rr_last == SRC_A);

    assign o_a_ready = grant_a && advance && !i_rst;
    assign o_b_ready = grant_b && advance && !i_rst;
    assign xfer      = o_a_ready || o_b_ready;

    // Operand select; noTexture ORs the texel up to white.
    assign tex_r   = grant_b ? (i_b_rTex | {TEX_W{i_b_noTexture}}) : (i_a_rTex | {TEX_W{i_a_noTexture}});
    assign tex_g   = grant_b ? (i_b_gTex | {TEX_W{i_b_noTexture}}) : (i_a_gTex | {TEX_W{i_a_noTexture}});
    assign tex_b   = grant_b ? (i_b_bTex | {TEX_W{i_b_noTexture}}) : (i_a_bTex | {TEX_W{i_a_noTexture}});
    assign gou_r   = grant_b ? i_b_rGouraud : i_a_rGouraud;
    assign gou_g   = grant_b ? i_b_gGouraud : i_a_gGouraud;
    assign gou_b   = grant_b ? i_b_bGouraud : i_a_bGouraud;
    assign tag_sel = grant_b ? i_b_tag : i_a_tag;

`ifdef SHADE_DITHER_EN
    logic       dither_sel;
    logic [1:0] x_sel;
    logic [1:0] y_sel;

    assign dither_sel = grant_b ? i_b_dither : i_a_dither;
    assign x_sel      = grant_b ? i_b_x : i_a_x;
    assign y_sel      = grant_b ? i_b_y : i_a_y;
    assign offset_sel = dither_sel ? dither_offset(x_sel, y_sel) : '0;
`else
    logic unused_dither;

    assign unused_dither = ^{i_a_x, i_a_y, i_a_dither, i_b_x, i_b_y, i_b_dither};
    assign offset_sel    = '0;
`endif

    // Pipeline control, sideband and round-robin state.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rr_last   <= SRC_B;
            s1_valid  <= 1'b0;
            s1_src    <= 1'b0;
            s1_tag    <= '0;
            s1_offset <= '0;
            o_valid   <= 1'b0;
            o_src     <= 1'b0;
            o_tag     <= '0;
            o_busy    <= 1'b0;
        end else begin
            if (xfer) begin
                rr_last <= grant_b ? SRC_B : SRC_A;
            end
            if (advance) begin
                s1_valid  <= xfer;
                s1_src    <= grant_b;
                s1_tag    <= tag_sel;
                s1_offset <= offset_sel;
                o_valid   <= s1_valid;
                o_src     <= s1_src;
                o_tag     <= s1_tag;
            end
            // A stall implies o_valid is set, so the pipe stays busy.
            o_busy <= advance ? (xfer || s1_valid) : 1'b1;
        end
    end

    shade_channel_mul u_mul_r (
        .clk     (clk),
        .rst     (i_rst),
        .load    (advance),
        .tex     (tex_r),
        .gouraud (gou_r),
        .offset  (s1_offset),
        .color   (o_r)
    );

    shade_channel_mul u_mul_g (
        .clk     (clk),
        .rst     (i_rst),
        .load    (advance),
        .tex     (tex_g),
        .gouraud (gou_g),
        .offset  (s1_offset),
        .color   (o_g)
    );

    shade_channel_mul u_mul_b (
        .clk     (clk),
        .rst     (i_rst),
        .load    (advance),
        .tex     (tex_b),
        .gouraud (gou_b),
        .offset  (s1_offset),
        .color   (o_b)
    );

endmodule

// File: tb/tb_shade_arbiter.sv
// Directed self-checking bench for shade_arbiter: reset, single-requester
// shading, clamping, dither (SHADE_DITHER_EN aware), alternating arbitration,
// output stall and mid-flight reset.
module tb_shade_arbiter;

    localparam int unsigned TAG_W = 8;
`ifdef SHADE_DITHER_EN
    localparam bit DITHER_ON = 1'b1;
`else
    localparam bit DITHER_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic i_rst;
    logic i_a_valid, o_a_ready, i_b_valid, o_b_ready;
    logic [4:0] i_a_rTex, i_a_gTex, i_a_bTex, i_b_rTex, i_b_gTex, i_b_bTex;
    logic i_a_noTexture, i_b_noTexture;
    logic [8:0] i_a_rGouraud, i_a_gGouraud, i_a_bGouraud;
    logic [8:0] i_b_rGouraud, i_b_gGouraud, i_b_bGouraud;
    logic [1:0] i_a_x, i_a_y, i_b_x, i_b_y;
    logic i_a_dither, i_b_dither;
    logic [TAG_W-1:0] i_a_tag, i_b_tag, o_tag;
    logic o_valid, i_ready, o_src, o_busy;
    logic [7:0] o_r, o_g, o_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shade_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .i_a_rTex(i_a_rTex), .i_a_gTex(i_a_gTex), .i_a_bTex(i_a_bTex),
        .i_a_noTexture(i_a_noTexture),
        .i_a_rGouraud(i_a_rGouraud), .i_a_gGouraud(i_a_gGouraud), .i_a_bGouraud(i_a_bGouraud),
        .i_a_x(i_a_x), .i_a_y(i_a_y), .i_a_dither(i_a_dither), .i_a_tag(i_a_tag),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
        .i_b_rTex(i_b_rTex), .i_b_gTex(i_b_gTex), .i_b_bTex(i_b_bTex),
        .i_b_noTexture(i_b_noTexture),
        .i_b_rGouraud(i_b_rGouraud), .i_b_gGouraud(i_b_gGouraud), .i_b_bGouraud(i_b_bGouraud),
        .i_b_x(i_b_x), .i_b_y(i_b_y), .i_b_dither(i_b_dither), .i_b_tag(i_b_tag),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_src(o_src), .o_tag(o_tag), .o_busy(o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] tex, input logic notex,
                         input logic [8:0] gou, input logic [1:0] x, input logic [1:0] y,
                         input logic d, input logic [7:0] tag);
        i_a_valid = v; i_a_rTex = tex; i_a_gTex = tex; i_a_bTex = tex; i_a_noTexture = notex;
        i_a_rGouraud = gou; i_a_gGouraud = gou; i_a_bGouraud = gou;
        i_a_x = x; i_a_y = y; i_a_dither = d; i_a_tag = tag;
    endtask

    task automatic set_b(input logic v, input logic [4:0] tex, input logic notex,
                         input logic [8:0] gou, input logic [1:0] x, input logic [1:0] y,
                         input logic d, input logic [7:0] tag);
        i_b_valid = v; i_b_rTex = tex; i_b_gTex = tex; i_b_bTex = tex; i_b_noTexture = notex;
        i_b_rGouraud = gou; i_b_gGouraud = gou; i_b_bGouraud = gou;
        i_b_x = x; i_b_y = y; i_b_dither = d; i_b_tag = tag;
    endtask

    task automatic do_reset();
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0);
        i_ready = 1'b1;
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h11);
        set_b(1, 31, 0, 128, 0, 0, 0, 8'h22);
        i_ready = 1'b1;
        i_rst = 1'b1;
        step();
        checks++; if (o_a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%b exp=0", o_a_ready); end
        checks++; if (o_b_ready !== 1'b0) begin failures++; $display("FAIL reset_b_ready got=%b exp=0", o_b_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if ({o_r, o_g, o_b, o_tag} !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {o_r, o_g, o_b, o_tag}); end
        step();
        i_rst = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_a_only();
        do_reset();
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h5A);
        #1;
        checks++; if (o_a_ready !== 1'b1) begin failures++; $display("FAIL a_only_ready got=%b exp=1", o_a_ready); end
        step();
        i_a_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL a_only_s1 got valid=%b busy=%b exp valid=0 busy=1", o_valid, o_busy); end
        step();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL a_only_valid got=%b exp=1", o_valid); end
        checks++; if ({o_r, o_g, o_b} !== {8'd124, 8'd124, 8'd124}) begin failures++; $display("FAIL a_only_rgb got=%0d,%0d,%0d exp=124,124,124", o_r, o_g, o_b); end
        checks++; if (o_src !== 1'b0 || o_tag !== 8'h5A) begin failures++; $display("FAIL a_only_side got src=%b tag=%h exp src=0 tag=5a", o_src, o_tag); end
        step();
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL a_only_drain got valid=%b busy=%b exp 0 0", o_valid, o_busy); end
    endtask

    task automatic test_b_only();
        logic [7:0] exp_g, exp_b;
        do_reset();
        // dither at (3,0) is +1 when enabled
        set_b(1, 0, 1, 511, 3, 0, 1, 8'hC3);
        i_b_gGouraud = 9'd256;
        i_b_bGouraud = 9'd64;
        exp_g = DITHER_ON ? 8'd249 : 8'd248;
        exp_b = DITHER_ON ? 8'd63 : 8'd62;
        #1;
        checks++; if (o_b_ready !== 1'b1 || o_a_ready !== 1'b0) begin failures++; $display("FAIL b_only_ready got a=%b b=%b exp a=0 b=1", o_a_ready, o_b_ready); end
        step();
        i_b_valid = 1'b0;
        step();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL b_only_valid got=%b exp=1", o_valid); end
        checks++; if (o_r !== 8'd255) begin failures++; $display("FAIL b_only_clamp_r got=%0d exp=255", o_r); end
        checks++; if (o_g !== exp_g || o_b !== exp_b) begin failures++; $display("FAIL b_only_gb got=%0d,%0d exp=%0d,%0d", o_g, o_b, exp_g, exp_b); end
        checks++; if (o_src !== 1'b1 || o_tag !== 8'hC3) begin failures++; $display("FAIL b_only_side got src=%b tag=%h exp src=1 tag=c3", o_src, o_tag); end
        step();
    endtask

    task automatic test_dither();
        int gou[6]    = '{128, 128, 128, 128, 0, 128};
        int xs[6]     = '{0, 3, 0, 1, 0, 0};
        int ys[6]     = '{0, 1, 3, 1, 0, 0};
        int den[6]    = '{1, 1, 1, 1, 1, 0};
        int exp_on[6] = '{120, 123, 127, 122, 0, 124};
        int exp_of[6] = '{124, 124, 124, 124, 0, 124};
        logic [7:0] exp_v;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_a(1, 31, 0, 9'(gou[i]), 2'(xs[i]), 2'(ys[i]), 1'(den[i]), 8'(i));
            exp_v = DITHER_ON ? 8'(exp_on[i]) : 8'(exp_of[i]);
            step();
            i_a_valid = 1'b0;
            step();
            checks++;
            if (o_valid !== 1'b1 || o_r !== exp_v || o_b !== exp_v) begin
                failures++;
                $display("FAIL dither_%0d got valid=%b r=%0d b=%0d exp r=b=%0d", i, o_valid, o_r, o_b, exp_v);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tag;
        logic       exp_a, exp_b;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                set_a(1, 31, 0, 128, 0, 0, 0, 8'(8'hA0 + k));
                set_b(1, 0, 1, 256, 0, 0, 0, 8'(8'hB0 + k));
            end else begin
                i_a_valid = 1'b0;
                i_b_valid = 1'b0;
            end
            #1;
            exp_a = (k < 6) && (k % 2 == 0);
            exp_b = (k < 6) && (k % 2 == 1);
            checks++;
            if (o_a_ready !== exp_a || o_b_ready !== exp_b) begin
                failures++;
                $display("FAIL b2b_grant_%0d got a=%b b=%b exp a=%b b=%b", k, o_a_ready, o_b_ready, exp_a, exp_b);
            end
            if (k >= 2) begin
                exp_tag = ((k - 2) % 2 == 0) ? 8'(8'hA0 + k - 2) : 8'(8'hB0 + k - 2);
                checks++;
                if (o_valid !== 1'b1 || o_tag !== exp_tag || o_src !== 1'((k - 2) % 2)
                    || o_r !== (((k - 2) % 2 == 0) ? 8'd124 : 8'd248)) begin
                    failures++;
                    $display("FAIL b2b_out_%0d got valid=%b tag=%h src=%b r=%0d exp tag=%h", k, o_valid, o_tag, o_src, o_r, exp_tag);
                end
            end else begin
                checks++;
                if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_early_%0d got valid=%b exp=0", k, o_valid); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h31);
        #1;
        checks++; if (o_a_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_a got=%b exp=1", o_a_ready); end
        step();
        i_a_valid = 1'b0;
        set_b(1, 0, 1, 256, 0, 0, 0, 8'h42);
        #1;
        checks++; if (o_b_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_b got=%b exp=1", o_b_ready); end
        step();
        i_ready = 1'b0;
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h53);
        set_b(1, 0, 1, 256, 0, 0, 0, 8'h64);
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_tag !== 8'h31 || o_src !== 1'b0 || o_r !== 8'd124 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold_%0d got valid=%b tag=%h src=%b r=%0d busy=%b exp 1 31 0 124 1", s, o_valid, o_tag, o_src, o_r, o_busy);
            end
            checks++;
            if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready_%0d got a=%b b=%b exp 0 0", s, o_a_ready, o_b_ready);
            end
            step();
        end
        i_ready = 1'b1;
        #1;
        checks++; if (o_a_ready !== 1'b1 || o_b_ready !== 1'b0 || o_tag !== 8'h31) begin failures++; $display("FAIL stall_release got a=%b b=%b tag=%h exp 1 0 31", o_a_ready, o_b_ready, o_tag); end
        step();
        i_a_valid = 1'b0;
        #1;
        checks++; if (o_tag !== 8'h42 || o_src !== 1'b1 || o_r !== 8'd248 || o_b_ready !== 1'b1) begin failures++; $display("FAIL stall_out42 got tag=%h src=%b r=%0d bready=%b", o_tag, o_src, o_r, o_b_ready); end
        step();
        i_b_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_tag !== 8'h53 || o_src !== 1'b0) begin failures++; $display("FAIL stall_out53 got valid=%b tag=%h src=%b", o_valid, o_tag, o_src); end
        step();
        checks++; if (o_valid !== 1'b1 || o_tag !== 8'h64 || o_src !== 1'b1) begin failures++; $display("FAIL stall_out64 got valid=%b tag=%h src=%b", o_valid, o_tag, o_src); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got valid=%b exp=0", o_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h71);
        step();
        i_a_valid = 1'b0;
        set_b(1, 0, 1, 256, 0, 0, 0, 8'h72);
        step();
        i_b_valid = 1'b0;
        set_a(1, 31, 0, 128, 0, 0, 0, 8'h73);
        i_rst = 1'b1;
        #1;
        checks++; if (o_a_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", o_a_ready); end
        step();
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_clear got valid=%b busy=%b exp 0 0", o_valid, o_busy); end
        i_rst = 1'b0;
        i_a_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_%0d got valid=%b tag=%h exp valid=0", c, o_valid, o_tag); end
        end
    endtask

    initial begin
        i_rst = 1'b0;
        i_ready = 1'b1;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_a_only();
        test_b_only();
        test_dither();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
